// File: rtl/bit_slice_loader_if.sv
// rtl/bit_slice_loader_if.sv - input word stream bundle for bit_slice_loader
interface bit_slice_loader_if #(
    parameter int WORD_W = 25
) ();
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;

    modport master (output in_valid, output in_word, input in_ready);
    modport slave  (input in_valid, input in_word, output in_ready);
endinterface

// File: rtl/bit_slice_loader.sv
// rtl/bit_slice_loader.sv - gathers one bit column from DEPTH words into pipe; optional SLICE_PARITY_EN
module bit_slice_loader #(
    parameter int WORD_W = 25,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               readData,
    input  logic [IDX_W-1:0]   num,
    bit_slice_loader_if.slave  in_if,
    output logic [DEPTH-1:0]   pipe,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef SLICE_PARITY_EN
    ,
    output logic               parity
`endif
);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0]   WORD_LIM = (IDX_W + 1)'(WORD_W);
    localparam logic [CNT_W-1:0] LAST_N   = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   num_q;
    logic [CNT_W-1:0]   n;
    logic               start;
    logic               xfer;
    logic [IDX_W-1:0]   sel;
    logic               slice_bit;
    logic [DEPTH-1:0]   pipe_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        start          = 1'b0;
        xfer           = 1'b0;
        in_if.in_ready = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (readData) begin
                    start     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_if.in_ready = 1'b1;
                busy           = 1'b1;
                xfer           = in_if.in_valid;
                if (xfer && n == LAST_N) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Column is counted from the MSB; an out-of-range column reads as zero via err.
    assign sel       = IDX_W'(WORD_W - 1) - num_q;
    assign slice_bit = ~err & in_if.in_word[sel];

    always_comb begin
        pipe_nxt    = pipe;
        pipe_nxt[n] = slice_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q  <= '0;
            n      <= '0;
            pipe   <= '0;
            err    <= 1'b0;
`ifdef SLICE_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (start) begin
            num_q  <= num;
            n      <= '0;
            pipe   <= '0;
            err    <= ({1'b0, num} >= WORD_LIM);
`ifdef SLICE_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (xfer) begin
            pipe <= pipe_nxt;
            if (n != LAST_N) n <= n + 1'b1;
`ifdef SLICE_PARITY_EN
            if (n == LAST_N) parity <= ^pipe_nxt;
`endif
        end
    end
endmodule

// File: doc/bit_slice_loader.md
BIT_SLICE_LOADER -- requirements
Module: bit_slice_loader

Interface
REQ-001 Parameter: WORD_W, 25, width of each input word.
REQ-002 Parameter: DEPTH, 64, number of words captured per load; pipe width.
REQ-003 Parameter: IDX_W, 5, width of num; SHALL satisfy 2**IDX_W >= WORD_W.
REQ-004 Port: clk  input  1  sole clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: readData  input  1  start request, sampled on clk.
REQ-007 Port: num  input  IDX_W  column select, latched at accepted start.
REQ-008 Port: in_valid  input  1  in_word valid.
REQ-009 Port: in_word  input  WORD_W  input data word.
REQ-010 Port: in_ready  output  1  loader accepts in_word this cycle.
REQ-011 Port: pipe  output  DEPTH  captured bit column.
REQ-012 Port: busy  output  1  load in progress.
REQ-013 Port: done  output  1  one-cycle pulse, load complete.
REQ-014 Port: err  output  1  sticky; latched num out of range for current load.

Function
REQ-015 FSM states IDLE, LOAD, DONE; single-cycle DONE state.
REQ-016 IDLE: readData=1 -> latch num into num_q, clear pipe to 0, clear counter n, set err = (num >= WORD_W), go LOAD.
REQ-017 LOAD: in_ready=1, busy=1; in IDLE and DONE in_ready=0, busy=0.
REQ-018 Transfer occurs only when in_valid & in_ready; non-transfer cycles leave pipe and n unchanged.
REQ-019 On transfer: pipe[n] <= in_word[WORD_W-1-num_q] (MSB-relative index); n <= n+1.
REQ-020 If err=1, transfers still counted but pipe[n] <= 0.
REQ-021 Transfer with n = DEPTH-1 -> go DONE; n not incremented past DEPTH-1.
REQ-022 DONE: done=1 for exactly that cycle; next cycle IDLE.
REQ-023 pipe holds its value after DONE until next accepted start or reset.
REQ-024 readData asserted in LOAD or DONE SHALL be ignored (no restart, no latch of num).
REQ-025 readData held high continuously: new load starts on first IDLE cycle, i.e. two cycles after done.
REQ-026 in_valid in IDLE/DONE: word dropped, no state change.
REQ-027 Load latency: done rises in the cycle after the DEPTH-th transfer; minimum DEPTH+1 cycles after start acceptance.
REQ-028 err updated only at start acceptance; remains until next start or reset.

Reset
REQ-029 rst=1 asynchronously forces IDLE, n=0, num_q=0, pipe=0, in_ready=0, busy=0, done=0, err=0.
REQ-030 rst during LOAD aborts the load; partial pipe contents discarded (zeroed).
REQ-031 After rst deasserts, first start accepted on the first clk edge with readData=1.

Configuration
REQ-032 Macro SLICE_PARITY_EN: when defined, add output parity (1 bit) = XOR of all pipe bits, registered, valid from the done cycle, held until next start, reset 0.
REQ-033 Without SLICE_PARITY_EN: no parity port, no parity logic; all other behaviour identical.

Verification (WORD_W=25, DEPTH=64)
REQ-034 Start num=0, 64 words alternating 25'h1000000 / 25'h0, in_valid always 1 -> done 65 cycles after start acceptance, pipe=64'h5555_5555_5555_5555, err=0.
REQ-035 Start num=24, words = index n (bit0 = n[0]) with in_valid toggled every other cycle -> pipe=64'hAAAA_AAAA_AAAA_AAAA, done after 64 transfers only.
REQ-036 Start num=30 -> err=1, 64 words all-ones -> pipe=0, done pulses once.
REQ-037 rst asserted after 20 transfers -> pipe=0, busy=0 immediately; new start num=5 with all-ones words -> pipe=64'hFFFF_FFFF_FFFF_FFFF.
REQ-038 readData pulsed with num=3 during LOAD (num_q=7) -> no restart, column 7 still used, single done pulse.
REQ-039 SLICE_PARITY_EN defined, load yielding pipe=64'h1 -> parity=1 at done; pipe=64'h3 -> parity=0.
